// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register.
// State encoding doubles as the occupancy count.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready, flush and bubbles.
// SKID selects a 2-entry skid buffer or a single register.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e       state_q, state_d;
            logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
            logic [DATA_W-1:0] main_data_q, main_data_d;
            logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
            logic [DATA_W-1:0] skid_data_q, skid_data_d;

            always_comb begin
                state_d     = state_q;
                main_ctrl_d = main_ctrl_q;
                main_data_d = main_data_q;
                skid_ctrl_d = skid_ctrl_q;
                skid_data_d = skid_data_q;
                if (flush_i) begin
                    state_d = PS_EMPTY;
                end else begin
                    unique case (state_q)
                        PS_EMPTY: begin
                            if (accept) begin
                                state_d     = PS_ONE;
                                main_ctrl_d = in_ctrl;
                                main_data_d = in_data;
                            end
                        end
                        PS_ONE: begin
                            if (accept && emit) begin
                                main_ctrl_d = in_ctrl;
                                main_data_d = in_data;
                            end else if (accept) begin
                                state_d     = PS_FULL;
                                skid_ctrl_d = in_ctrl;
                                skid_data_d = in_data;
                            end else if (emit) begin
                                state_d = PS_EMPTY;
                            end
                        end
                        PS_FULL: begin
                            if (emit) begin
                                state_d     = PS_ONE;
                                main_ctrl_d = skid_ctrl_q;
                                main_data_d = skid_data_q;
                            end
                        end
                        default: state_d = PS_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q     <= PS_EMPTY;
                    main_ctrl_q <= '0;
                    main_data_q <= '0;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    state_q     <= state_d;
                    main_ctrl_q <= main_ctrl_d;
                    main_data_q <= main_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                    skid_data_q <= skid_data_d;
                end
            end

            // Ready comes straight off the state flop: no path from out_ready.
            assign in_ready  = (state_q != PS_FULL);
            assign out_valid = (state_q != PS_EMPTY);
            assign out_ctrl  = out_valid ? main_ctrl_q : '0;
            assign out_data  = main_data_q;
            assign occupancy = state_q;
        end else begin : g_reg
            logic              valid_q, valid_d;
            logic [CTRL_W-1:0] ctrl_q, ctrl_d;
            logic [DATA_W-1:0] data_q, data_d;

            always_comb begin
                valid_d = valid_q;
                ctrl_d  = ctrl_q;
                data_d  = data_q;
                if (flush_i) begin
                    valid_d = 1'b0;
                end else if (accept) begin
                    valid_d = 1'b1;
                    ctrl_d  = in_ctrl;
                    data_d  = in_data;
                end else if (emit) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    ctrl_q  <= ctrl_d;
                    data_q  <= data_d;
                end
            end

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign out_ctrl  = valid_q ? ctrl_q : '0;
            assign out_data  = data_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic, SKID=1 and SKID=0 side by side.
// Stimulus pushes expected beats; negedge monitors pop and compare.
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        flush_i = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1;
    logic [2:0]  out_ctrl1;
    logic [31:0] out_data1;
    logic [1:0]  occ1;
    logic        in_ready0, out_valid0;
    logic [2:0]  out_ctrl0;
    logic [31:0] out_data0;
    logic [1:0]  occ0;

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(3), .SKID(1)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(3), .SKID(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occ0)
    );

    typedef struct packed {
        logic [2:0]  c;
        logic [31:0] d;
    } beat_t;

    beat_t q1[$];
    beat_t q0[$];
    beat_t e1, e0;
    int checks = 0;
    int passed = 0;
    int emits1 = 0, emits0 = 0;
    int acc1 = 0, acc0 = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    task automatic drive(input logic iv, input logic [2:0] c,
                         input logic [31:0] d, input logic ordy,
                         input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush_i   = fl;
        #1;
        if (rst_n && iv && !fl) begin
            if (in_ready1) begin
                q1.push_back(beat_t'({c, d}));
                acc1++;
            end
            if (in_ready0) begin
                q0.push_back(beat_t'({c, d}));
                acc0++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid1 && out_ready) begin
                emits1++;
                if (q1.size() == 0) begin
                    checks++;
                    $display("FAIL skid_unexpected: got %h expected none",
                             out_data1);
                end else begin
                    e1 = q1.pop_front();
                    chk("skid_ctrl", 32'(out_ctrl1), 32'(e1.c));
                    chk("skid_data", out_data1, e1.d);
                end
            end
            if (!out_valid1) chk("skid_bubble", 32'(out_ctrl1), 32'd0);
            if (flush_i) q1.delete();

            if (out_valid0 && out_ready) begin
                emits0++;
                if (q0.size() == 0) begin
                    checks++;
                    $display("FAIL reg_unexpected: got %h expected none",
                             out_data0);
                end else begin
                    e0 = q0.pop_front();
                    chk("reg_ctrl", 32'(out_ctrl0), 32'(e0.c));
                    chk("reg_data", out_data0, e0.d);
                end
            end
            if (!out_valid0) chk("reg_bubble", 32'(out_ctrl0), 32'd0);
            if (flush_i) q0.delete();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_e1, s_e0, s_a1, s_a0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid1", 32'(out_valid1), 32'd0);
        chk("rst_ctrl1", 32'(out_ctrl1), 32'd0);
        chk("rst_data1", out_data1, 32'd0);
        chk("rst_occ1", 32'(occ1), 32'd0);
        chk("rst_ready1", 32'(in_ready1), 32'd1);
        chk("rst_valid0", 32'(out_valid0), 32'd0);
        chk("rst_ready0", 32'(in_ready0), 32'd1);
        #9 rst_n = 1'b1;

        // single beat, one-cycle latency
        drive(1'b1, 3'b101, 32'hDEAD_BEEF, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        chk("t1_valid", 32'(out_valid1), 32'd1);
        chk("t1_ctrl", 32'(out_ctrl1), 32'd5);
        chk("t1_data", out_data1, 32'hDEAD_BEEF);
        chk("t1_occ1", 32'(occ1), 32'd1);
        chk("t1_occ0", 32'(occ0), 32'd1);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        chk("t1_occ1_end", 32'(occ1), 32'd0);
        chk("t1_occ0_end", 32'(occ0), 32'd0);

        // fill skid with out_ready low
        drive(1'b1, 3'd1, 32'd1, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 32'd2, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        chk("t2_ready1", 32'(in_ready1), 32'd0);
        chk("t2_occ1", 32'(occ1), 32'd2);
        chk("t2_ready0", 32'(in_ready0), 32'd0);
        chk("t2_occ0", 32'(occ0), 32'd1);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        chk("t2_ready1_end", 32'(in_ready1), 32'd1);
        chk("t2_occ1_end", 32'(occ1), 32'd0);

        // 100-beat stream
        s_e1 = emits1; s_e0 = emits0;
        s_a1 = acc1; s_a0 = acc0;
        for (int i = 0; i < 100; i++)
            drive(1'b1, 3'(i), 32'h1000 + 32'(i), 1'b1, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        chk("t3_acc1", 32'(acc1 - s_a1), 32'd100);
        chk("t3_emit1", 32'(emits1 - s_e1), 32'd100);
        chk("t3_acc0", 32'(acc0 - s_a0), 32'd100);
        chk("t3_emit0", 32'(emits0 - s_e0), 32'd100);

        // flush while FULL with incoming beat
        drive(1'b1, 3'd1, 32'hA1, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 32'hB2, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 32'hC3, 1'b0, 1'b0);
        chk("t4_full", 32'(occ1), 32'd2);
        drive(1'b1, 3'd7, 32'hF1, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        chk("t4_valid1", 32'(out_valid1), 32'd0);
        chk("t4_ctrl1", 32'(out_ctrl1), 32'd0);
        chk("t4_occ1", 32'(occ1), 32'd0);
        chk("t4_data1", out_data1, 32'hA1);
        chk("t4_ready1", 32'(in_ready1), 32'd1);
        chk("t4_valid0", 32'(out_valid0), 32'd0);
        chk("t4_occ0", 32'(occ0), 32'd0);
        drive(1'b1, 3'd3, 32'h55, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);

        // async reset while FULL
        drive(1'b1, 3'd1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 32'h22, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        chk("t5_full", 32'(occ1), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid1", 32'(out_valid1), 32'd0);
        chk("t5_ctrl1", 32'(out_ctrl1), 32'd0);
        chk("t5_data1", out_data1, 32'd0);
        chk("t5_occ1", 32'(occ1), 32'd0);
        chk("t5_ready1", 32'(in_ready1), 32'd1);
        chk("t5_valid0", 32'(out_valid0), 32'd0);
        q1.delete();
        q0.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;

        // single register with toggling out_ready
        s_a0 = acc0;
        drive(1'b1, 3'd1, 32'h61, 1'b1, 1'b0);
        chk("t6_ready_a", 32'(in_ready0), 32'd1);
        drive(1'b1, 3'd2, 32'h62, 1'b0, 1'b0);
        chk("t6_ready_b", 32'(in_ready0), 32'd0);
        drive(1'b1, 3'd3, 32'h63, 1'b1, 1'b0);
        chk("t6_ready_c", 32'(in_ready0), 32'd1);
        drive(1'b1, 3'd4, 32'h64, 1'b1, 1'b0);
        chk("t6_ready_d", 32'(in_ready0), 32'd1);
        chk("t6_acc0", 32'(acc0 - s_a0), 32'd3);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);

        chk("end_q1_empty", 32'(q1.size()), 32'd0);
        chk("end_q0_empty", 32'(q0.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
